// File: rtl/fn_sw_packer.sv
// rtl/fn_sw_packer.sv - packs the 1-bit fn_sw result stream into WIDTH-bit words
// Shift register plus output register, so a word can drain while the next one fills.
module fn_sw_packer #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_vld,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_ones,
  output logic [CW-1:0]    out_len
);

  logic [WIDTH-1:0] shift, shift_nxt;
  logic [CW-1:0]    cnt, cnt_inc, ones, len;
  logic             full, xfer, acc;

  assign xfer    = full & (~out_vld | out_rdy);
  assign in_rdy  = res & (~full | xfer);
  assign acc     = in_vld & in_rdy;
  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    shift_nxt = shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) shift_nxt[i] = in_bit;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      shift    <= '0;
      cnt      <= '0;
      ones     <= '0;
      len      <= '0;
      full     <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_ones <= '0;
      out_len  <= '0;
    end else begin
      if (xfer) begin
        out_data <= shift;
        out_ones <= ones;
        out_len  <= len;
        out_vld  <= 1'b1;
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end

      // The shift register is cleared on transfer so unused upper bits of a short word read as 0.
      if (xfer) begin
        shift <= {{(WIDTH-1){1'b0}}, acc & in_bit};
        cnt   <= acc ? CW'(1) : '0;
        ones  <= (acc & in_bit) ? CW'(1) : '0;
        full  <= acc & in_last;
        if (acc && in_last) len <= CW'(1);
      end else if (acc) begin
        shift <= shift_nxt;
        cnt   <= cnt_inc;
        ones  <= ones + {{(CW-1){1'b0}}, in_bit};
        if (cnt_inc == CW'(WIDTH) || in_last) begin
          full <= 1'b1;
          len  <= cnt_inc;
        end
      end
    end
  end

endmodule
